// File: rtl/rrat_free_list_pkg.sv
// Shared out-of-order core configuration: register counts, index widths and
// the typedefs used between rename, commit and the retirement-side free list.
package ooo_config;

  localparam int unsigned NUM_RREGS = 32;
  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_RREGS;
  localparam int unsigned FL_BITS   = $clog2(FL_DEPTH);
  localparam int unsigned RREG_W    = $clog2(NUM_RREGS);
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
  localparam int unsigned MAP_W     = NUM_RREGS * PREG_W;

  typedef logic [RREG_W-1:0]  rreg_t;
  typedef logic [PREG_W-1:0]  preg_t;
  // Extra MSB over the slot index distinguishes full from empty.
  typedef logic [FL_BITS:0]   fl_ptr_t;

  typedef struct packed {
    logic  valid;
    rreg_t rd;
    preg_t pd;
  } commit_t;

endpackage

// File: rtl/rrat_free_list_free_list.sv
// Circular free list of physical registers with push, pop, head restore and
// a sticky overflow flag; pointers carry one wrap bit above the slot index.
module free_list
  import ooo_config::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  preg_t   push_pd,
  input  logic    pop,
  input  logic    restore,
  input  fl_ptr_t restore_head,
  output fl_ptr_t head,
  output preg_t   head_pd_c,
  output logic    empty_c,
  output logic    full_c,
  output logic    overflow
);

  localparam fl_ptr_t TAIL_RST = fl_ptr_t'({1'b1, {FL_BITS{1'b0}}});

  fl_ptr_t tail;
  preg_t   slots [FL_DEPTH];

  assign empty_c   = (head == tail);
  assign full_c    = (head[FL_BITS] != tail[FL_BITS]) &&
                     (head[FL_BITS-1:0] == tail[FL_BITS-1:0]);
  assign head_pd_c = slots[head[FL_BITS-1:0]];

  // Head: a restore wins over a same-cycle pop; pops on empty are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (restore) begin
      head <= restore_head;
    end else if (pop && !empty_c) begin
      head <= head + fl_ptr_t'(1);
    end
  end

  // Tail and storage: the list comes out of reset holding every non-arch preg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail <= TAIL_RST;
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        slots[k] <= preg_t'(NUM_RREGS + k);
      end
    end else if (push && !full_c) begin
      slots[tail[FL_BITS-1:0]] <= push_pd;
      tail                     <= tail + fl_ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && full_c) begin
      overflow <= 1'b1;
    end
  end

  push_while_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full_c))
    else $error("free_list: push while full");

endmodule

// File: rtl/rrat_free_list.sv
// Retirement RAT plus the free list it feeds: each commit remaps the
// architectural destination and recycles the physical reg it superseded.
module rrat_free_list
  import ooo_config::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_valid,
  input  logic [RREG_W-1:0]     commit_rd,
  input  logic [PREG_W-1:0]     commit_pd,
  input  logic                  alloc_req,
  output logic                  alloc_valid,
  output logic [PREG_W-1:0]     alloc_pd,
  output logic [FL_BITS:0]      fl_head,
  input  logic                  flush,
  input  logic [FL_BITS:0]      flush_fl_head,
  output logic [MAP_W-1:0]      rrat_map,
  output logic                  fl_overflow
);

  commit_t commit_c;
  logic    remap_c;
  preg_t   old_pd_c;
  logic    empty_c;
  logic    full_c;
  preg_t   rrat [NUM_RREGS];

  assign commit_c = '{valid: commit_valid, rd: rreg_t'(commit_rd), pd: preg_t'(commit_pd)};

  // x0 is hardwired, so commits to it neither remap nor recycle.
  assign remap_c  = commit_c.valid && (commit_c.rd != rreg_t'(0));
  assign old_pd_c = rrat[commit_c.rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RREGS; i++) begin
        rrat[i] <= preg_t'(i);
      end
    end else if (remap_c) begin
      rrat[commit_c.rd] <= commit_c.pd;
    end
  end

  always_comb begin
    rrat_map = '0;
    for (int unsigned i = 0; i < NUM_RREGS; i++) begin
      rrat_map[i*PREG_W +: PREG_W] = rrat[i];
    end
  end

  // Commits are older than any mispredicted branch, so they push even on flush.
  free_list u_free_list (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (remap_c),
    .push_pd      (old_pd_c),
    .pop          (alloc_req),
    .restore      (flush),
    .restore_head (fl_ptr_t'(flush_fl_head)),
    .head         (fl_head),
    .head_pd_c    (alloc_pd),
    .empty_c      (empty_c),
    .full_c       (full_c),
    .overflow     (fl_overflow)
  );

  assign alloc_valid = !empty_c;

endmodule
